// File: rtl/cla_seq_pkg.sv
// Shared constants and FSM state type for the word-serial CLA add/sub sequencer.
package cla_seq_pkg;
    localparam int WORD_W    = 16;
    localparam int MAX_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;
endpackage

// File: rtl/SixteenBit_LookAhead_Adder.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a group-level lookahead carry chain.
module SixteenBit_LookAhead_Adder (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C_in,
    output logic [15:0] S,
    output logic        C_out
);
    logic [15:0] p, g, c;
    logic [3:0]  gp, gg;
    logic [4:0]  gc;

    assign p = A ^ B;
    assign g = A & B;

    always_comb begin
        gp = '0;
        gg = '0;
        gc = '0;
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        gc[0] = C_in;
        for (int k = 0; k < 4; k++)
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        // Group carries come from the lookahead chain; bits inside a group resolve locally.
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int j = 1; j < 4; j++)
                c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
        end
    end

    assign S     = p ^ c;
    assign C_out = gc[4];
endmodule

// File: rtl/cla_wide_add_sequencer.sv
// Multi-precision add/subtract: one shared 16-bit CLA walks WORDS words LSW-first,
// carrying between words through a register, with valid/ready on both sides.
module cla_wide_add_sequencer
    import cla_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W*WORDS-1:0] op_a,
    input  logic [WORD_W*WORDS-1:0] op_b,
    input  logic                    sub,
    input  logic                    carry_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W*WORDS-1:0] sum,
    output logic                    carry_out,
    output logic                    overflow
);
    localparam int W     = WORD_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    seq_state_t         state, state_nxt;
    logic [W-1:0]       a_reg, b_reg, sum_reg;
    logic [IDX_W-1:0]   idx;
    logic               c_reg, carry_out_r, overflow_r;
    logic [WORD_W-1:0]  word_a, word_b, adder_s;
    logic               adder_co;
    logic               last_word;

    always_comb begin
        word_a = '0;
        word_b = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
                word_a = a_reg[w*WORD_W +: WORD_W];
                word_b = b_reg[w*WORD_W +: WORD_W];
            end
        end
    end

    SixteenBit_LookAhead_Adder u_cla (
        .A     (word_a),
        .B     (word_b),
        .C_in  (c_reg),
        .S     (adder_s),
        .C_out (adder_co)
    );

    assign last_word = (idx == IDX_W'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_word) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            sum_reg     <= '0;
            idx         <= '0;
            c_reg       <= 1'b0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1, so the incoming carry is forced to 1.
                        a_reg <= op_a;
                        b_reg <= sub ? ~op_b : op_b;
                        c_reg <= sub ? 1'b1 : carry_in;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int w = 0; w < WORDS; w++)
                        if (idx == IDX_W'(w))
                            sum_reg[w*WORD_W +: WORD_W] <= adder_s;
                    c_reg <= adder_co;
                    idx   <= idx + IDX_W'(1);
                    if (last_word) begin
                        carry_out_r <= adder_co;
                        overflow_r  <= (a_reg[W-1] == b_reg[W-1]) &&
                                       (adder_s[WORD_W-1] != a_reg[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;
endmodule
